// File: rtl/lvm_pkg.sv
// Shared definitions for the memory sequencer front-end of the 16-bit cpu core.
package lvm_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned DEFAULT_ADDR_W = 16;

    // Step schedule states; the encoding is fixed so it can be matched in waveforms.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StFwait = 3'd2,
        StDacc  = 3'd3,
        StDwait = 3'd4,
        StStep  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/mem_sequencer.sv
// Serialises instruction fetch, data access and the commit strobe for one cpu step
// over a single-port synchronous RAM with 1-cycle read latency.
module mem_sequencer
    import lvm_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic [WORD_W-1:0] i_pc,
    input  logic [WORD_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_out,
    input  logic              i_write,
    output logic [WORD_W-1:0] o_instruction,
    output logic [WORD_W-1:0] o_data,
    output logic              o_cpu_step,
    output logic              o_busy,
    output logic [WORD_W-1:0] o_retired,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [WORD_W-1:0] i_mem_rdata
);

    seq_state_e        r_state;
    logic [WORD_W-1:0] r_instruction;
    logic [WORD_W-1:0] r_data;
    logic [WORD_W-1:0] r_retired;

    // Step FSM plus the instruction/data capture registers and retired counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_instruction <= '0;
            r_data        <= '0;
            r_retired     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_run) r_state <= StFetch;
                end
                StFetch: r_state <= StFwait;
                StFwait: begin
                    r_instruction <= i_mem_rdata;
                    r_state       <= StDacc;
                end
                StDacc: begin
                    // Stores commit in DACC and skip the read-return cycle.
                    r_state <= i_write ? StStep : StDwait;
                end
                StDwait: begin
                    r_data  <= i_mem_rdata;
                    r_state <= StStep;
                end
                StStep: begin
                    r_retired <= r_retired + 16'd1;
                    r_state   <= i_run ? StFetch : StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // RAM port and strobe decode; addresses are live because cpu decode settles in-step.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        o_cpu_step  = 1'b0;
        o_busy      = (r_state != StIdle);
        case (r_state)
            StFetch: o_mem_addr = i_pc[ADDR_W-1:0];
            StDacc: begin
                o_mem_addr  = i_addr[ADDR_W-1:0];
                o_mem_wdata = i_out;
                // Gated by reset so an aborting step can never corrupt RAM.
                o_mem_we    = i_write & ~i_reset;
            end
            StStep:  o_cpu_step = ~i_reset;
            default: ;
        endcase
    end

    assign o_instruction = r_instruction;
    assign o_data        = r_data;
    assign o_retired     = r_retired;

endmodule
